// File: rtl/toy_mcore_mm.sv
// toy_mcore_mm: output-stationary ROWS x COLS systolic matrix-multiply core.
// A columns enter at the left edge and B rows at the top edge, both skewed so
// that beat t meets itself at PE(r,c) in cycle t+r+c+1. Each PE keeps its own
// C[r][c] accumulator. After the last beat the array is flushed and the
// results are drained one row per handshake.
// Reset is synchronous and active-high even though the port is named rst_n.
module toy_mcore_mm #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int K_W    = 16,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [K_W-1:0]          cfg_k,
    input  logic                    cfg_acc,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROWS*DATA_W-1:0]  in_a,
    input  logic [COLS*DATA_W-1:0]  in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COLS*ACC_W-1:0]   out_data,
    output logic [ROW_W-1:0]        out_row,
    output logic                    busy,
    output logic                    done
);

    localparam int FL_W = $clog2(ROWS + COLS);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(ROWS + COLS - 2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_FLUSH   = 2'd2,
        S_DRAIN   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [K_W-1:0]   beat_q, beat_d;
    logic [FL_W-1:0]  flush_q, flush_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             done_q, done_d;
    logic             clear_acc;
    logic             accept;

    // Operand words carry {valid, data}; bit DATA_W is the valid flag.
    logic [DATA_W:0] a_inj  [ROWS];
    logic [DATA_W:0] b_inj  [COLS];
    logic [DATA_W:0] a_edge [ROWS];
    logic [DATA_W:0] b_edge [COLS];
    logic [DATA_W:0] a_pe_q [ROWS][COLS];
    logic [DATA_W:0] b_pe_q [ROWS][COLS];
    logic signed [ACC_W-1:0] acc_q [ROWS][COLS];

    assign in_ready  = (state_q == S_COMPUTE);
    assign out_valid = (state_q == S_DRAIN);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign out_row   = row_q;
    assign accept    = in_valid & in_ready;

    // Signed DATA_W x DATA_W product, sign-extended (or wrapped) to ACC_W and added.
    function automatic logic signed [ACC_W-1:0] mac(
        input logic signed [ACC_W-1:0] acc,
        input logic [DATA_W:0]         a,
        input logic [DATA_W:0]         b
    );
        logic signed [2*DATA_W-1:0] a_ext;
        logic signed [2*DATA_W-1:0] b_ext;
        logic signed [2*DATA_W-1:0] prod;
        a_ext = (2*DATA_W)'($signed(a[DATA_W-1:0]));
        b_ext = (2*DATA_W)'($signed(b[DATA_W-1:0]));
        prod  = a_ext * b_ext;
        return acc + ACC_W'(prod);
    endfunction

    // Control state register.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples the pre-edge values; blocking here would create order-dependent races.
        if (rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            beat_q  <= beat_d;
            flush_q <= flush_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: job start, beat counting, flush timing and row drain.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d   = state_q;
        k_d       = k_q;
        beat_d    = beat_q;
        flush_d   = flush_q;
        row_d     = row_q;
        done_d    = 1'b0;
        clear_acc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d       = cfg_k;
                    beat_d    = '0;
                    flush_d   = '0;
                    row_d     = '0;
                    clear_acc = !cfg_acc;
                    state_d   = (cfg_k != '0) ? S_COMPUTE : S_DRAIN;
                end
            end
            S_COMPUTE: begin
                if (accept) begin
                    beat_d = beat_q + K_W'(1);
                    if (beat_q + K_W'(1) == k_q) begin
                        flush_d = '0;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // The last beat needs ROWS+COLS-1 cycles to reach PE(ROWS-1,COLS-1).
                if (flush_q == FL_LAST) begin
                    row_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    flush_d = flush_q + FL_W'(1);
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Edge injection: an accepted beat enters with valid=1, otherwise a zero bubble.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            a_inj[r] = accept ? {1'b1, in_a[r*DATA_W +: DATA_W]} : '0;
        end
        for (int c = 0; c < COLS; c++) begin
            b_inj[c] = accept ? {1'b1, in_b[c*DATA_W +: DATA_W]} : '0;
        end
    end

    // Left-edge skew: row r of A is delayed r cycles before entering column 0.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        if (r == 0) begin : g_direct
            assign a_edge[r] = a_inj[r];
        end else begin : g_delay
            logic [DATA_W:0] dly_q [r];
            // Shift register of depth r.
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    for (int i = 0; i < r; i++) dly_q[i] <= '0;
                end else begin
                    dly_q[0] <= a_inj[r];
                    for (int i = 1; i < r; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign a_edge[r] = dly_q[r-1];
        end
    end

    // Top-edge skew: column c of B is delayed c cycles before entering row 0.
    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        if (c == 0) begin : g_direct
            assign b_edge[c] = b_inj[c];
        end else begin : g_delay
            logic [DATA_W:0] dly_q [c];
            // Shift register of depth c.
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    for (int i = 0; i < c; i++) dly_q[i] <= '0;
                end else begin
                    dly_q[0] <= b_inj[c];
                    for (int i = 1; i < c; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign b_edge[c] = dly_q[c-1];
        end
    end

    // Systolic operand movement: a flows right, b flows down, one PE per cycle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    a_pe_q[r][c] <= '0;
                    b_pe_q[r][c] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                a_pe_q[r][0] <= a_edge[r];
                for (int c = 1; c < COLS; c++) a_pe_q[r][c] <= a_pe_q[r][c-1];
            end
            for (int c = 0; c < COLS; c++) begin
                b_pe_q[0][c] <= b_edge[c];
                for (int r = 1; r < ROWS; r++) b_pe_q[r][c] <= b_pe_q[r-1][c];
            end
        end
    end

    // PE accumulators: multiply-accumulate when a valid operand pair is present.
    always_ff @(posedge clk) begin
        // NOTE: the accumulator array is reset explicitly because a reset job
        // must start from zero; it is small flop storage, not a RAM macro.
        if (rst_n || clear_acc) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) acc_q[r][c] <= '0;
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (a_pe_q[r][c][DATA_W] && b_pe_q[r][c][DATA_W]) begin
                        acc_q[r][c] <= mac(acc_q[r][c], a_pe_q[r][c], b_pe_q[r][c]);
                    end
                end
            end
        end
    end

    // Result row mux; zero whenever no row is being offered.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int c = 0; c < COLS; c++) out_data[c*ACC_W +: ACC_W] = acc_q[row_q][c];
        end
    end

endmodule

// File: tb/tb_toy_mcore_mm.sv
// Self-checking bench for toy_mcore_mm: directed and random jobs compared
// against a matrix model that sums a[r]*b[c] over accepted beats.
// A second instance with ACC_W=8 receives the same stimulus to exercise wrap.
module tb_toy_mcore_mm;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int K_W    = 16;
    localparam int ROW_W  = 2;
    localparam int AW     = ROWS * DATA_W;
    localparam int BW     = COLS * DATA_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n, start, cfg_acc, in_valid, out_ready;
    logic [K_W-1:0]         cfg_k;
    logic [AW-1:0]          in_a;
    logic [BW-1:0]          in_b;
    logic                   in_ready, out_valid, busy, done;
    logic [COLS*ACC_W-1:0]  out_data;
    logic [ROW_W-1:0]       out_row;
    logic                   in_ready8, out_valid8, busy8, done8;
    logic [COLS*8-1:0]      out_data8;
    logic [ROW_W-1:0]       out_row8;

    toy_mcore_mm u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k), .cfg_acc(cfg_acc),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .busy(busy), .done(done)
    );

    toy_mcore_mm #(.ACC_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k), .cfg_acc(cfg_acc),
        .in_valid(in_valid), .in_ready(in_ready8), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
        .out_row(out_row8), .busy(busy8), .done(done8)
    );

    int checks = 0;
    int errors = 0;
    logic signed [31:0] mdl [ROWS][COLS];
    logic [AW-1:0] qa [$];
    logic [BW-1:0] qb [$];
    bit [6:0] pat = 7'b1011001;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mdl[r][c] = '0;
    endtask

    task automatic model_beat(input logic [AW-1:0] a, input logic [BW-1:0] b);
        logic signed [31:0] av, bv;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                av = 32'(signed'(a[r*DATA_W +: DATA_W]));
                bv = 32'(signed'(b[c*DATA_W +: DATA_W]));
                mdl[r][c] = mdl[r][c] + av * bv;
            end
        end
    endtask

    function automatic logic [127:0] exp_row(input int r);
        logic [127:0] v;
        for (int c = 0; c < COLS; c++) v[c*32 +: 32] = mdl[r][c];
        return v;
    endfunction

    function automatic logic [31:0] exp_row8(input int r);
        logic [31:0] v;
        for (int c = 0; c < COLS; c++) v[c*8 +: 8] = mdl[r][c][7:0];
        return v;
    endfunction

    task automatic fill_const(input int k, input logic [AW-1:0] a, input logic [BW-1:0] b);
        qa.delete(); qb.delete();
        for (int i = 0; i < k; i++) begin qa.push_back(a); qb.push_back(b); end
    endtask

    task automatic fill_random(input int k);
        qa.delete(); qb.delete();
        for (int i = 0; i < k; i++) begin
            qa.push_back(AW'($urandom));
            qb.push_back(BW'($urandom));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b1; start = 1'b0; cfg_k = '0; cfg_acc = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        model_clear();
    endtask

    // One complete job: start, feed beats (vmode 0=steady, 1=fixed toggle, 2=random),
    // wait for drain, read every row with an optional stall, check done timing.
    task automatic run_job(input int k, input bit acc, input int vmode,
                           input int stall_row, input int stall_cyc, input bit poke);
        int hand, cyc, rdy_cnt, wait_cyc;
        bit both, v;
        logic [2:0] pi;
        hand = 0; cyc = 0; rdy_cnt = 0; wait_cyc = 0; both = 1'b0;
        @(negedge clk);
        start = 1'b1; cfg_k = K_W'(k); cfg_acc = acc;
        if (!acc) model_clear();
        @(negedge clk);
        start = 1'b0; cfg_k = '0; cfg_acc = 1'b0;
        check("busy_after_start", 128'(busy), 128'(1));
        while (hand < k && cyc < 300) begin
            pi = 3'(cyc % 7);
            case (vmode)
                0:       v = 1'b1;
                1:       v = pat[pi];
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v; in_a = qa[hand]; in_b = qb[hand];
            if (in_ready) rdy_cnt++;
            if (in_ready && out_valid) both = 1'b1;
            if (in_ready && v) begin
                model_beat(qa[hand], qb[hand]);
                hand++;
            end
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("beats_accepted", 128'(hand), 128'(k));
        check("ready_drop", 128'(in_ready), 128'(0));
        while (!out_valid && wait_cyc < 100) begin
            if (in_ready) rdy_cnt++;
            wait_cyc++;
            @(negedge clk);
        end
        check("flush_len", 128'(wait_cyc), 128'((k > 0) ? ROWS + COLS - 1 : 0));
        check("ready_cycles", 128'(rdy_cnt), 128'((vmode == 0) ? k : cyc));
        for (int r = 0; r < ROWS; r++) begin
            if (r == stall_row) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_cyc; s++) begin
                    if (poke && s == 0) begin start = 1'b1; cfg_k = K_W'(5); cfg_acc = 1'b0; end
                    else begin start = 1'b0; cfg_k = '0; end
                    check("stall_valid", 128'(out_valid), 128'(1));
                    check("stall_row", 128'(out_row), 128'(r));
                    check("stall_data", 128'(out_data), exp_row(r));
                    @(negedge clk);
                end
                start = 1'b0; cfg_k = '0;
            end
            out_ready = 1'b1;
            if (in_ready) both = 1'b1;
            check("row_valid", 128'(out_valid), 128'(1));
            check("row_index", 128'(out_row), 128'(r));
            check("row_data", 128'(out_data), exp_row(r));
            check("row_valid8", 128'(out_valid8), 128'(1));
            check("row_data8", 128'(out_data8), 128'(exp_row8(r)));
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("done_pulse", 128'(done), 128'(1));
        check("valid_drop", 128'(out_valid), 128'(0));
        check("idle_after", 128'(busy), 128'(0));
        @(negedge clk);
        check("done_once", 128'(done), 128'(0));
        check("ready_valid_excl", 128'(both), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] a;
        logic [BW-1:0] b;

        // Reset state.
        do_reset();
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_out_row", 128'(out_row), 128'(0));
        check("rst8_outputs", 128'({in_ready8, out_valid8, busy8, done8, out_row8}), 128'(0));
        check("rst8_out_data", 128'(out_data8), 128'(0));

        // Broadcast column times all-ones row.
        fill_const(1, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd1, 8'd1, 8'd1, 8'd1});
        run_job(1, 1'b0, 0, -1, 0, 1'b0);

        // Identity A, steady then toggled in_valid.
        qa.delete(); qb.delete();
        for (int k = 0; k < 4; k++) begin
            a = AW'(1) << (8 * k);
            b = {8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1), 8'(4*k)};
            qa.push_back(a); qb.push_back(b);
        end
        run_job(4, 1'b0, 0, -1, 0, 1'b0);
        run_job(4, 1'b0, 1, -1, 0, 1'b0);

        // Signed product and accumulator wrap in the narrow instance.
        fill_const(1, {4{8'hFD}}, {4{8'd5}});
        run_job(1, 1'b0, 0, -1, 0, 1'b0);
        fill_const(2, {4{8'd127}}, {4{8'd127}});
        run_job(2, 1'b0, 0, -1, 0, 1'b0);

        // Backpressure on row 1 with an ignored start, then accumulate again.
        fill_random(3);
        run_job(3, 1'b0, 0, 1, 3, 1'b1);
        run_job(3, 1'b1, 2, -1, 0, 1'b0);

        // Random jobs.
        for (int j = 0; j < 4; j++) begin
            int k;
            k = $urandom_range(1, 6);
            fill_random(k);
            run_job(k, 1'($urandom_range(0, 1)), 2, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
        end

        // Reset in the middle of COMPUTE with beats still in flight.
        fill_random(4);
        @(negedge clk);
        start = 1'b1; cfg_k = K_W'(4); cfg_acc = 1'b0;
        @(negedge clk);
        start = 1'b0; cfg_k = '0;
        in_valid = 1'b1; in_a = qa[0]; in_b = qb[0];
        @(negedge clk);
        in_a = qa[1]; in_b = qb[1];
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_in_ready", 128'(in_ready), 128'(0));
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        fill_const(1, {4{8'd1}}, {4{8'd1}});
        run_job(1, 1'b1, 0, -1, 0, 1'b0);

        // Zero-length job drains cleared accumulators.
        qa.delete(); qb.delete();
        run_job(0, 1'b0, 0, -1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
